// File: rtl/decoder_pkg.sv
// ----------------------------------------------------------------------------
// decoder_pkg
// Shared constants for decoder_scan: mode encodings, FSM state encoding and
// a one-hot helper sized for the widest supported select (MAX_N bits).
// ----------------------------------------------------------------------------
package decoder_pkg;

    // Widest select the one-hot helper supports; callers truncate its result.
    localparam int unsigned MAX_N = 8;
    localparam int unsigned MAX_W = 1 << MAX_N;

    // mode input encoding
    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DIRECT = 2'd1;
    localparam logic [1:0] ST_SCAN   = 2'd2;

    // One-hot decode of sel; caller casts down to its 2**N width.
    function automatic logic [MAX_W-1:0] onehot(input logic [MAX_N-1:0] sel);
        logic [MAX_W-1:0] v;
        v      = '0;
        v[sel] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/decoder_scan_if.sv
// ----------------------------------------------------------------------------
// decoder_scan_if
// Control and select-line bundle of decoder_scan.
//   en    : enable (0 = all lines inactive, scan state frozen)
//   mode  : MODE_DIRECT / MODE_SCAN
//   x     : select in direct mode, start index on scan entry
//   y     : registered one-hot select lines (polarity set by the decoder)
//   idx   : registered index currently decoded onto y
//   valid : exactly one y line active
//   wrap  : one-cycle pulse when the scan index rolls over to 0
// master = controller side, slave = decoder side.
// ----------------------------------------------------------------------------
interface decoder_scan_if #(
    parameter int unsigned N = 2
);
    localparam int unsigned W = 1 << N;

    logic         en;
    logic         mode;
    logic [N-1:0] x;
    logic [W-1:0] y;
    logic [N-1:0] idx;
    logic         valid;
    logic         wrap;

    modport master (
        output en,
        output mode,
        output x,
        input  y,
        input  idx,
        input  valid,
        input  wrap
    );

    modport slave (
        input  en,
        input  mode,
        input  x,
        output y,
        output idx,
        output valid,
        output wrap
    );
endinterface

// File: rtl/decoder_scan_tick_gen.sv
// ----------------------------------------------------------------------------
// tick_gen
// Scan-step prescaler: counts 0..TICK_DIV-1 while enabled and flags the
// terminal count. The count holds while disabled, so a paused scan resumes
// with its remaining count.
//   clk, reset : clock, synchronous active-high reset
//   clear      : restart the count at 0 (wins over enable)
//   enable     : advance the count this cycle
//   tick_c     : combinational, high when enabled at terminal count
// ----------------------------------------------------------------------------
module tick_gen #(
    parameter int unsigned TICK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick_c
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    assign tick_c = enable && (cnt_q == TERM);

    // prescaler count
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= tick_c ? '0 : cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/decoder_scan.sv
// ----------------------------------------------------------------------------
// decoder_scan
// Registered N-to-2**N one-hot decoder with enable and an auto-scan mode.
// Direct mode decodes x with one cycle of latency; scan mode steps its own
// index through every line, one step per TICK_DIV cycles.
//   clk, reset : clock, synchronous active-high reset
//   bus        : decoder_scan_if.slave (en, mode, x in; y, idx, valid, wrap out)
// Parameters: N (select width, 1..MAX_N), TICK_DIV (cycles per scan step,
// >= 1), ACTIVE_LOW (1 = inactive lines driven high).
// ----------------------------------------------------------------------------
module decoder_scan
    import decoder_pkg::*;
#(
    parameter int unsigned N          = 2,
    parameter int unsigned TICK_DIV   = 4,
    parameter bit          ACTIVE_LOW = 1'b0
) (
    input logic           clk,
    input logic           reset,
    decoder_scan_if.slave bus
);

    localparam int unsigned  W        = 1 << N;
    localparam logic [W-1:0] Y_IDLE   = ACTIVE_LOW ? {W{1'b1}} : {W{1'b0}};
    localparam logic [N-1:0] IDX_LAST = {N{1'b1}};

    logic [1:0]   state_q, state_d;
    logic [N-1:0] idx_q,   idx_d;
    logic [W-1:0] y_q,     y_d;
    logic         valid_q, valid_d;
    logic         wrap_q,  wrap_d;
    // Set by reset and DIRECT: the next SCAN entry must reload idx from x.
    logic         armed_q, armed_d;

    logic reload_c;
    logic scan_c;
    logic psc_clear_c;
    logic psc_en_c;
    logic tick_c;

    assign reload_c    = armed_q || (state_q == ST_DIRECT);
    assign scan_c      = bus.en && (bus.mode == MODE_SCAN);
    assign psc_clear_c = bus.en && ((bus.mode == MODE_DIRECT) || reload_c);
    assign psc_en_c    = scan_c && !reload_c;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .reset  (reset),
        .clear  (psc_clear_c),
        .enable (psc_en_c),
        .tick_c (tick_c)
    );

    // Next state and next registered outputs
    always_comb begin
        state_d = ST_IDLE;
        idx_d   = idx_q;
        y_d     = Y_IDLE;
        valid_d = 1'b0;
        wrap_d  = 1'b0;
        armed_d = armed_q;

        if (!bus.en) begin
            state_d = ST_IDLE;
        end else if (bus.mode == MODE_DIRECT) begin
            state_d = ST_DIRECT;
            idx_d   = bus.x;
            armed_d = 1'b1;
            valid_d = 1'b1;
            y_d     = W'(onehot(MAX_N'(idx_d))) ^ Y_IDLE;
        end else begin
            state_d = ST_SCAN;
            valid_d = 1'b1;
            if (reload_c) begin
                // Entry: start from x; no wrap even if idx rolls to 0 here.
                idx_d   = bus.x;
                armed_d = 1'b0;
            end else if (tick_c) begin
                idx_d  = idx_q + N'(1);
                wrap_d = (idx_q == IDX_LAST);
            end
            y_d = W'(onehot(MAX_N'(idx_d))) ^ Y_IDLE;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            y_q     <= Y_IDLE;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
            armed_q <= 1'b1;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            y_q     <= y_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
            armed_q <= armed_d;
        end
    end

    assign bus.y     = y_q;
    assign bus.idx   = idx_q;
    assign bus.valid = valid_q;
    assign bus.wrap  = wrap_q;

endmodule

// File: tb/tb_decoder_scan.sv
// ----------------------------------------------------------------------------
// tb_decoder_scan
// Directed bench for decoder_scan: instance A (N=2, TICK_DIV=4, active-high)
// and instance B (N=3, TICK_DIV=2, active-low) on a shared clock and reset.
// ----------------------------------------------------------------------------
module tb_decoder_scan;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    decoder_scan_if #(.N(2)) bus_a ();
    decoder_scan_if #(.N(3)) bus_b ();

    decoder_scan #(
        .N          (2),
        .TICK_DIV   (4),
        .ACTIVE_LOW (1'b0)
    ) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    decoder_scan #(
        .N          (3),
        .TICK_DIV   (2),
        .ACTIVE_LOW (1'b1)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic [3:0] ey, input logic [1:0] ei,
                         input logic ev, input logic ew);
        chk({tag, ".y"},     32'(bus_a.y),     32'(ey));
        chk({tag, ".idx"},   32'(bus_a.idx),   32'(ei));
        chk({tag, ".valid"}, 32'(bus_a.valid), 32'(ev));
        chk({tag, ".wrap"},  32'(bus_a.wrap),  32'(ew));
    endtask

    task automatic chk_b(input string tag, input logic [7:0] ey, input logic [2:0] ei,
                         input logic ev, input logic ew);
        chk({tag, ".y"},     32'(bus_b.y),     32'(ey));
        chk({tag, ".idx"},   32'(bus_b.idx),   32'(ei));
        chk({tag, ".valid"}, 32'(bus_b.valid), 32'(ev));
        chk({tag, ".wrap"},  32'(bus_b.wrap),  32'(ew));
    endtask

    initial begin
        bus_a.en = 1'b0; bus_a.mode = 1'b0; bus_a.x = 2'd0;
        bus_b.en = 1'b0; bus_b.mode = 1'b0; bus_b.x = 3'd0;

        // reset held two cycles
        tick();
        tick();
        chk_a("rst_a", 4'b0000, 2'd0, 1'b0, 1'b0);
        chk_b("rst_b", 8'hFF, 3'd0, 1'b0, 1'b0);

        // first direct decode
        reset = 1'b0;
        bus_a.en = 1'b1; bus_a.mode = 1'b0; bus_a.x = 2'd2;
        tick();
        chk_a("dir_x2", 4'b0100, 2'd2, 1'b1, 1'b0);

        // direct sweep
        bus_a.x = 2'd0; tick(); chk_a("sweep0", 4'b0001, 2'd0, 1'b1, 1'b0);
        bus_a.x = 2'd1; tick(); chk_a("sweep1", 4'b0010, 2'd1, 1'b1, 1'b0);
        bus_a.x = 2'd2; tick(); chk_a("sweep2", 4'b0100, 2'd2, 1'b1, 1'b0);
        bus_a.x = 2'd3; tick(); chk_a("sweep3", 4'b1000, 2'd3, 1'b1, 1'b0);

        // scan entry at x=3; later x changes must be ignored
        bus_a.mode = 1'b1; bus_a.x = 2'd3;
        tick(); chk_a("scan3_c0", 4'b1000, 2'd3, 1'b1, 1'b0);
        bus_a.x = 2'd1;
        tick(); chk_a("scan3_c1", 4'b1000, 2'd3, 1'b1, 1'b0);
        tick(); chk_a("scan3_c2", 4'b1000, 2'd3, 1'b1, 1'b0);
        tick(); chk_a("scan3_c3", 4'b1000, 2'd3, 1'b1, 1'b0);
        tick(); chk_a("scan0_wrap", 4'b0001, 2'd0, 1'b1, 1'b1);
        tick(); chk_a("scan0_c1", 4'b0001, 2'd0, 1'b1, 1'b0);
        tick(); chk_a("scan0_c2", 4'b0001, 2'd0, 1'b1, 1'b0);
        tick(); chk_a("scan0_c3", 4'b0001, 2'd0, 1'b1, 1'b0);
        tick(); chk_a("scan1_c0", 4'b0010, 2'd1, 1'b1, 1'b0);
        tick(); chk_a("scan1_c1", 4'b0010, 2'd1, 1'b1, 1'b0);

        // pause mid-step for three cycles
        bus_a.en = 1'b0;
        tick(); chk_a("hold_c0", 4'b0000, 2'd1, 1'b0, 1'b0);
        tick(); chk_a("hold_c1", 4'b0000, 2'd1, 1'b0, 1'b0);
        tick(); chk_a("hold_c2", 4'b0000, 2'd1, 1'b0, 1'b0);
        bus_a.en = 1'b1;
        tick(); chk_a("resume_c0", 4'b0010, 2'd1, 1'b1, 1'b0);
        tick(); chk_a("resume_c1", 4'b0010, 2'd1, 1'b1, 1'b0);
        tick(); chk_a("resume_step", 4'b0100, 2'd2, 1'b1, 1'b0);

        // reset mid-scan, then re-entry reloads from x
        reset = 1'b1;
        tick(); chk_a("rst_mid", 4'b0000, 2'd0, 1'b0, 1'b0);
        reset = 1'b0; bus_a.x = 2'd1;
        tick(); chk_a("reent_c0", 4'b0010, 2'd1, 1'b1, 1'b0);
        tick(); chk_a("reent_c1", 4'b0010, 2'd1, 1'b1, 1'b0);
        tick(); chk_a("reent_c2", 4'b0010, 2'd1, 1'b1, 1'b0);
        tick(); chk_a("reent_c3", 4'b0010, 2'd1, 1'b1, 1'b0);

        // en drops exactly at terminal count: no step
        bus_a.en = 1'b0;
        tick(); chk_a("term_en0", 4'b0000, 2'd1, 1'b0, 1'b0);
        bus_a.en = 1'b1;
        tick(); chk_a("term_step", 4'b0100, 2'd2, 1'b1, 1'b0);

        // SCAN -> DIRECT -> SCAN reloads; entry onto 0 does not pulse wrap
        bus_a.mode = 1'b0; bus_a.x = 2'd3;
        tick(); chk_a("toggle_dir", 4'b1000, 2'd3, 1'b1, 1'b0);
        bus_a.mode = 1'b1; bus_a.x = 2'd0;
        tick(); chk_a("toggle_scan", 4'b0001, 2'd0, 1'b1, 1'b0);

        // DIRECT -> IDLE -> SCAN still reloads from x
        bus_a.mode = 1'b0; bus_a.x = 2'd2;
        tick(); chk_a("dis_dir", 4'b0100, 2'd2, 1'b1, 1'b0);
        bus_a.en = 1'b0;
        tick(); chk_a("dis_idle", 4'b0000, 2'd2, 1'b0, 1'b0);
        bus_a.en = 1'b1; bus_a.mode = 1'b1; bus_a.x = 2'd1;
        tick(); chk_a("dis_scan", 4'b0010, 2'd1, 1'b1, 1'b0);

        // active-low N=3 instance
        bus_a.en = 1'b0;
        bus_b.en = 1'b1; bus_b.mode = 1'b0; bus_b.x = 3'd5;
        tick(); chk_b("al_dir5", 8'b1101_1111, 3'd5, 1'b1, 1'b0);
        bus_b.en = 1'b0;
        tick(); chk_b("al_off", 8'hFF, 3'd5, 1'b0, 1'b0);
        bus_b.en = 1'b1; bus_b.mode = 1'b1; bus_b.x = 3'd7;
        tick(); chk_b("al_scan7_c0", 8'h7F, 3'd7, 1'b1, 1'b0);
        tick(); chk_b("al_scan7_c1", 8'h7F, 3'd7, 1'b1, 1'b0);
        tick(); chk_b("al_wrap", 8'hFE, 3'd0, 1'b1, 1'b1);
        tick(); chk_b("al_scan0_c1", 8'hFE, 3'd0, 1'b1, 1'b0);
        tick(); chk_b("al_scan1", 8'hFD, 3'd1, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
